// File: rtl/ifetch_prefetch_buffer.sv
// ifetch_prefetch_buffer
//   Instruction fetch front end for the lc3b pipeline. A small FSM issues one
//   I-cache read at a time and pushes {pc, instruction} pairs into a DEPTH-entry
//   prefetch FIFO. The IF/ID latch pops the head with flow_IFID. A redirect
//   flushes the FIFO and drops any in-flight response.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   redirect, redirect_pc redirect the fetch stream to redirect_pc
//   mem_read, mem_address read request (held until mem_resp) and its address
//   mem_rdata, mem_resp   returned instruction and one-cycle completion strobe
//   flow_IFID             IF/ID accepts the head entry this cycle
//   inst_valid            FIFO non-empty
//   inst_out, inst_pc     head instruction and its address (zero when empty)
//   stall_fetch           no instruction available, pipeline injects a NOP
//
// Optional build macro FETCH_PERF_EN adds:
//   perf_stall_cycles[31:0]  cycles with stall_fetch=1, saturating
//   perf_discards[15:0]      responses dropped because of a redirect, saturating
module ifetch_prefetch_buffer #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               PC_STEP  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             mem_read,
  output logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_resp,
  input  logic             flow_IFID,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] inst_pc,
  output logic             stall_fetch
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [15:0]      perf_discards
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [WIDTH-1:0] inst_mem_q [DEPTH];

  logic             push;
  logic             flush;
  logic             pop_req;
  logic             pop_ok;
  logic [CNT_W-1:0] cnt_after_pop;
  logic [WIDTH-1:0] next_addr;

  assign pop_req       = flow_IFID && (count_q != '0);
  // A redirect discards the head along with everything else, so the pop is void.
  assign pop_ok        = pop_req && !redirect;
  assign cnt_after_pop = count_q - CNT_W'(pop_req);
  assign next_addr     = req_addr_q + WIDTH'(PC_STEP);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    flush      = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
        end else if (cnt_after_pop < CNT_W'(DEPTH)) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_pc;
          // The read cannot be cancelled; wait out its response unless it is here now.
          state_d    = mem_resp ? IDLE : DISCARD;
        end else if (mem_resp) begin
          push       = 1'b1;
          fetch_pc_d = next_addr;
          // Room left after this push: keep the port busy with the next address.
          if (cnt_after_pop < CNT_W'(DEPTH - 1)) begin
            req_addr_d = next_addr;
          end else begin
            state_d    = IDLE;
          end
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage holds data only; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= req_addr_q;
      inst_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign mem_read    = (state_q != IDLE);
  assign mem_address = req_addr_q;
  assign inst_valid  = (count_q != '0);
  assign inst_out    = inst_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign inst_pc     = inst_valid ? pc_mem_q[rd_ptr_q]   : '0;
  assign stall_fetch = !inst_valid;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] disc_cnt_q;
  logic        drop;

  assign drop = mem_resp && (((state_q == REQ) && redirect) || (state_q == DISCARD));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      disc_cnt_q  <= '0;
    end else begin
      if (stall_fetch && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (drop && (disc_cnt_q != '1)) begin
        disc_cnt_q <= disc_cnt_q + 16'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_discards     = disc_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
module tb_ifetch_prefetch_buffer;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        flow_IFID;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic        stall_fetch;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_discards;
`endif

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int resp_cnt = 0;
  int exp_stall = 0;
  logic [15:0] exp_inst[$];
  logic [15:0] exp_req[$];

  ifetch_prefetch_buffer #(
    .WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000), .PC_STEP(2)
  ) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_read(mem_read), .mem_address(mem_address), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .flow_IFID(flow_IFID), .inst_valid(inst_valid),
    .inst_out(inst_out), .inst_pc(inst_pc), .stall_fetch(stall_fetch)
`ifdef FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_discards(perf_discards)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_resp(input int budget);
    int n;
    n = 0;
    while (mem_resp !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk("wait_resp_timeout", {31'd0, mem_resp}, 32'd1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_inst.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({name, "_drain_left"}, exp_inst.size(), 0);
    chk({name, "_req_left"}, exp_req.size(), 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    redirect = 1'b0;
    flow_IFID = 1'b0;
    mem_lat = 1;
    steps(n);
  endtask

  // Memory: responds on the (mem_lat+1)-th cycle that mem_read is held high.
  initial begin
    int cnt;
    cnt = 0;
    mem_resp = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (reset || !mem_read) begin
        cnt = 0;
        mem_resp = 1'b0;
      end else begin
        cnt++;
        if (cnt > mem_lat) begin
          mem_resp = 1'b1;
          mem_rdata = mem_address ^ 16'hA5A5;
          cnt = 0;
        end else begin
          mem_resp = 1'b0;
        end
      end
    end
  end

  // Monitor: checks request addresses at each response and every accepted head entry.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        resp_cnt++;
        if (exp_req.size() != 0) begin
          e = exp_req.pop_front();
          chk("req_addr", {16'd0, mem_address}, {16'd0, e});
        end
      end
      if (inst_valid === 1'b1 && flow_IFID && !redirect && !reset) begin
        if (exp_inst.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop actual_pc=%h required=none t=%0t", inst_pc, $time);
        end else begin
          e = exp_inst.pop_front();
          chk("inst_pc", {16'd0, inst_pc}, {16'd0, e});
          chk("inst_out", {16'd0, inst_out}, {16'd0, e ^ 16'hA5A5});
        end
      end
      if (reset) exp_stall = 0;
      else if (stall_fetch === 1'b1) exp_stall++;
    end
  end

`ifdef FETCH_PERF_EN
  initial begin
    forever begin
      @(posedge clk);
      #3;
      chk("perf_stall", perf_stall_cycles, exp_stall);
    end
  end
`endif

  initial begin
    int base;
    int n;
    reset = 1'b1;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    flow_IFID = 1'b0;

    // Reset state
    steps(2);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall_fetch}, 32'd1);
    chk("rst_inst_out", {16'd0, inst_out}, 32'd0);
    chk("rst_inst_pc", {16'd0, inst_pc}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_disc", {16'd0, perf_discards}, 32'd0);
`endif

    // Sequential stream with continuous acceptance
    foreach (exp_inst[i]) exp_inst.delete();
    for (int a = 0; a < 8; a += 2) begin
      exp_inst.push_back(16'(a));
      exp_req.push_back(16'(a));
    end
    reset = 1'b0;
    flow_IFID = 1'b1;
    wait_resp(10);
    step();
    chk("latency_valid", {31'd0, inst_valid}, 32'd1);
    chk("latency_pc", {16'd0, inst_pc}, 32'h0000);
    drain("seq", 60);
    flow_IFID = 1'b0;

    // Fill with no acceptance, then one pop re-issues at 0x0008
    do_reset(1);
    for (int a = 0; a < 8; a += 2) exp_req.push_back(16'(a));
    base = resp_cnt;
    reset = 1'b0;
    steps(20);
    chk("fill_resps", resp_cnt - base, 4);
    chk("fill_mem_read", {31'd0, mem_read}, 32'd0);
    chk("fill_valid", {31'd0, inst_valid}, 32'd1);
    exp_inst.push_back(16'h0000);
    exp_req.push_back(16'h0008);
    flow_IFID = 1'b1;
    step();
    flow_IFID = 1'b0;
    steps(10);
    chk("refill_resps", resp_cnt - base, 5);
    chk("refill_mem_read", {31'd0, mem_read}, 32'd0);
    for (int a = 2; a < 10; a += 2) exp_inst.push_back(16'(a));
    flow_IFID = 1'b1;
    drain("fill", 20);
    flow_IFID = 1'b0;

    // Redirect while 0x0006 is outstanding; a second redirect lands in DISCARD
    do_reset(1);
    for (int a = 0; a < 8; a += 2) exp_req.push_back(16'(a));
    reset = 1'b0;
    n = 0;
    while (!(mem_read && mem_address == 16'h0006 && !mem_resp) && n < 30) begin
      step();
      n++;
    end
    chk("reach_0006", {16'd0, mem_address}, 32'h0006);
    mem_lat = 3;
    redirect = 1'b1;
    redirect_pc = 16'h2000;
    step();
    chk("disc_addr_a", {16'd0, mem_address}, 32'h0006);
    chk("disc_read", {31'd0, mem_read}, 32'd1);
    chk("disc_flush", {31'd0, inst_valid}, 32'd0);
    redirect_pc = 16'h3000;
    step();
    redirect = 1'b0;
    chk("disc_addr_b", {16'd0, mem_address}, 32'h0006);
    exp_req.push_back(16'h3000);
    exp_req.push_back(16'h3002);
    exp_inst.push_back(16'h3000);
    exp_inst.push_back(16'h3002);
    wait_resp(6);
    chk("disc_addr_resp", {16'd0, mem_address}, 32'h0006);
    mem_lat = 1;
    flow_IFID = 1'b1;
    drain("redir", 30);
    flow_IFID = 1'b0;
`ifdef FETCH_PERF_EN
    chk("perf_disc_one", {16'd0, perf_discards}, 32'd1);
`endif

    // Redirect coinciding with a response while the IF/ID side tries to pop
    do_reset(1);
    for (int a = 0; a < 8; a += 2) exp_req.push_back(16'(a));
    reset = 1'b0;
    steps(20);
    mem_lat = 3;
    exp_inst.push_back(16'h0000);
    exp_req.push_back(16'h0008);
    flow_IFID = 1'b1;
    step();
    flow_IFID = 1'b0;
    wait_resp(8);
    chk("coinc_valid_before", {31'd0, inst_valid}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 16'h4000;
    flow_IFID = 1'b1;
    step();
    redirect = 1'b0;
    chk("coinc_flush", {31'd0, inst_valid}, 32'd0);
    chk("coinc_idle", {31'd0, mem_read}, 32'd0);
    exp_req.push_back(16'h4000);
    exp_inst.push_back(16'h4000);
    mem_lat = 1;
    drain("coinc", 20);
    flow_IFID = 1'b0;
    mem_lat = 3;
    n = 0;
    while (!(mem_read && !mem_resp) && n < 20) begin
      step();
      n++;
    end
    chk("second_inflight", {31'd0, mem_read}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 16'h5000;
    step();
    redirect = 1'b0;
    steps(10);
`ifdef FETCH_PERF_EN
    chk("perf_disc_two", {16'd0, perf_discards}, 32'd2);
`endif

    // Address wrap at 0xFFFE, then reset during an outstanding read
    do_reset(2);
    exp_req.push_back(16'hFFFE);
    exp_req.push_back(16'h0000);
    exp_req.push_back(16'h0002);
    exp_inst.push_back(16'hFFFE);
    exp_inst.push_back(16'h0000);
    exp_inst.push_back(16'h0002);
    reset = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    flow_IFID = 1'b1;
    step();
    redirect = 1'b0;
    drain("wrap", 30);
    flow_IFID = 1'b0;
    n = 0;
    while (!mem_read && n < 10) begin
      step();
      n++;
    end
    chk("midrst_busy", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    step();
    chk("midrst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("midrst_valid", {31'd0, inst_valid}, 32'd0);
    chk("midrst_stall", {31'd0, stall_fetch}, 32'd1);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch_buffer.md
Name: ifetch_prefetch_buffer

Overview:
Parametrised next-generation instruction fetch front end for the lc3b pipeline. Decouples instruction memory from the IF/ID latch through a DEPTH-entry prefetch FIFO of {pc, instruction} pairs. Supports redirect (branch, jump, trap) with flush of queued and in-flight fetches. Sits between the I-cache port (read/resp handshake) and the IF/ID pipeline register.

Parameters:
WIDTH, 16, instruction and address width in bits
DEPTH, 4, prefetch FIFO entries; power of two, 2..16
RESET_PC, 16'h0000, fetch PC after reset
PC_STEP, 2, byte increment between sequential fetches

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
redirect  input  1  redirect fetch stream this cycle
redirect_pc  input  WIDTH  new fetch address when redirect=1
mem_read  output  1  instruction read request; held high until mem_resp
mem_address  output  WIDTH  address of the outstanding request; stable while mem_read=1
mem_rdata  input  WIDTH  instruction data, valid when mem_resp=1
mem_resp  input  1  one-cycle completion of the outstanding read
flow_IFID  input  1  IF/ID accepts the head entry this cycle
inst_valid  output  1  FIFO non-empty
inst_out  output  WIDTH  head instruction
inst_pc  output  WIDTH  address of head instruction
stall_fetch  output  1  inst_valid=0 (pipeline must inject NOP)

Behaviour:
- Reset: fetch_pc=RESET_PC, FIFO empty (count=0, pointers 0), FSM=IDLE, mem_read=0, inst_valid=0, stall_fetch=1, inst_out/inst_pc=0.
- FSM states: IDLE, REQ, DISCARD. At most one outstanding memory read.
- IDLE: if count<DEPTH (counting a same-cycle pop) and no redirect, latch req_addr=fetch_pc and go REQ. mem_read asserts the cycle after the decision.
- REQ: mem_read=1, mem_address=req_addr. On mem_resp without redirect: push {req_addr, mem_rdata}, fetch_pc=req_addr+PC_STEP (mod 2^WIDTH, wraps silently). If space remains after push/pop, issue the next request back-to-back (stay REQ, new req_addr); otherwise go IDLE.
- Redirect (any state): flush FIFO (count=0); fetch_pc=redirect_pc; same-cycle pop and push are ignored. If in REQ without same-cycle mem_resp, go DISCARD. If mem_resp coincides, drop the data and go IDLE.
- DISCARD: mem_read stays 1 with the old address until mem_resp, then drop the data and go IDLE. A further redirect in DISCARD only updates fetch_pc.
- Pop: flow_IFID=1 and inst_valid=1 advances the head. flow_IFID with an empty FIFO has no effect. Push and pop in the same cycle with the FIFO full is legal; count is unchanged.
- Outputs inst_out/inst_pc/inst_valid are registered FIFO head; no combinational path from mem_rdata. Minimum latency: mem_resp at cycle N means inst_valid=1 at N+1.
- Best case, with a 1-cycle memory, the block sustains one push per two cycles (request, resp).
- Reset mid-transaction: immediate return to reset state, mem_read drops next cycle. Memory must tolerate an abandoned request on reset.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_stall_cycles[31:0] (cycles with stall_fetch=1 after reset) and perf_discards[15:0] (responses dropped due to redirect). Both saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then 1-cycle memory returning mem_rdata=addr^16'hA5A5, flow_IFID=1 -> inst_pc sequence 0x0000,0x0002,0x0004 with matching data, no duplicates or gaps.
- flow_IFID=0 with DEPTH=4 -> exactly 4 pushes, then mem_read=0 and FSM IDLE. One pop re-issues a read at address 0x0008.
- Redirect to 0x3000 while a read to 0x0006 is outstanding (resp 3 cycles later) -> mem_address stays 0x0006 until resp, data dropped, next read 0x3000, first inst_pc=0x3000.
- Redirect coinciding with mem_resp and flow_IFID=1 with the FIFO full -> count=0, no push, next request to redirect_pc.
- Fetch at 0xFFFE -> next sequential request 0x0000.
- FETCH_PERF_EN defined, 2 redirects with in-flight reads -> perf_discards=2. Stall counter equals observed stall_fetch=1 cycles.
